// File: rtl/tensor_pkg.sv
// tensor_pkg: shared types and helpers for the tensor_mma unit.
//   state_e    : sequencing states (idle, row-by-row compute, result held)
//   sum_width  : bit width that holds a full-precision N-term dot product plus addend
//   sat_wrap   : range check of a full sum against a DW-bit signed range, returning
//                either the clamped value or the raw value (caller keeps the low DW bits)
package tensor_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCompute = 2'd1,
      StDone    = 2'd2
   } state_e;

   // Full sums are carried through sat_wrap at this width; supports DW up to 30.
   localparam int unsigned MaxSumW = 64;

   typedef struct packed {
      logic [MaxSumW-1:0] val;
      logic               ovf;
   } clamp_t;

   function automatic int unsigned sum_width(input int unsigned dw, input int unsigned n);
      return 2 * dw + $clog2(n) + 1;
   endfunction

   // With sat set, out-of-range values are clamped to the DW-bit limits; otherwise the
   // value passes through and truncation to DW bits performs the wrap.
   function automatic clamp_t sat_wrap(input logic signed [MaxSumW-1:0] v,
                                       input int unsigned               dw,
                                       input logic                      sat);
      logic signed [MaxSumW-1:0] hi;
      logic signed [MaxSumW-1:0] lo;
      clamp_t                    r;
      hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo    = -hi - 64'sd1;
      r.ovf = (v > hi) || (v < lo);
      if (sat && (v > hi)) begin
         r.val = hi;
      end else if (sat && (v < lo)) begin
         r.val = lo;
      end else begin
         r.val = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/tensor_dot.sv
// tensor_dot: one combinational dot-product lane.
//   row    in  DW*N  N signed elements, element k at bits DW*k
//   col    in  DW*N  N signed elements, element k at bits DW*k
//   addend in  DW    signed value added to the dot product (zero when not accumulating)
//   res    out DW    saturated (SAT=1) or wrapped (SAT=0) result
//   ovf    out 1     full-precision sum is outside the DW-bit signed range
module tensor_dot
   import tensor_pkg::*;
#(
   parameter int unsigned N   = 4,
   parameter int unsigned DW  = 8,
   parameter int unsigned SAT = 1
) (
   input  logic [DW*N-1:0] row,
   input  logic [DW*N-1:0] col,
   input  logic [DW-1:0]   addend,
   output logic [DW-1:0]   res,
   output logic            ovf
);

   localparam int unsigned SumW = sum_width(DW, N);

   logic signed [DW-1:0]   row_e [N];
   logic signed [DW-1:0]   col_e [N];
   logic signed [DW-1:0]   add_e;
   logic signed [SumW-1:0] sum;
   clamp_t                 cl;
   logic                   unused_hi;

   for (genvar k = 0; k < N; k++) begin : g_elem
      assign row_e[k] = row[k*DW +: DW];
      assign col_e[k] = col[k*DW +: DW];
   end

   assign add_e = addend;

   // Operands are sign-extended to the full sum width so no partial product can overflow.
   always_comb begin
      sum = SumW'(add_e);
      for (int k = 0; k < N; k++) begin
         sum = sum + SumW'(row_e[k]) * SumW'(col_e[k]);
      end
      cl = sat_wrap(MaxSumW'(sum), DW, SAT != 0);
   end

   assign res       = cl.val[DW-1:0];
   assign ovf       = cl.ovf;
   assign unused_hi = ^cl.val[MaxSumW-1:DW];

endmodule

// File: rtl/tensor_mma.sv
// tensor_mma: handshaked D = A*B + C on NxN signed DW-bit tiles, one output row per cycle.
//   clk        in  1        rising-edge clock
//   reset      in  1        asynchronous, active-low; clears all state
//   in_valid   in  1        operand set offered
//   in_ready   out 1        unit idle and able to accept operands
//   acc_en     in  1        add C when set, else treat C as zero (sampled on acceptance)
//   rs         in  DW*N*N   A, row-major
//   rt         in  DW*N*N   B, column-major (B[k][j] at bits DW*(j*N+k))
//   rc         in  DW*N*N   C, row-major
//   out_valid  out 1        result held on tensor_out
//   out_ready  in  1        consumer takes the result
//   tensor_out out DW*N*N   D, row-major
//   ovf        out 1        some element of the result saturated or wrapped
module tensor_mma
   import tensor_pkg::*;
#(
   parameter int unsigned N   = 4,
   parameter int unsigned DW  = 8,
   parameter int unsigned SAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              acc_en,
   input  logic [DW*N*N-1:0] rs,
   input  logic [DW*N*N-1:0] rt,
   input  logic [DW*N*N-1:0] rc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW*N*N-1:0] tensor_out,
   output logic              ovf
);

   localparam int unsigned TileW = DW * N * N;
   localparam int unsigned RowW  = DW * N;
   localparam int unsigned CntW  = $clog2(N);
   localparam logic [CntW-1:0] LastRow = CntW'(N - 1);

   state_e            state_q, state_d;
   logic [CntW-1:0]   row_q, row_d;
   logic [TileW-1:0]  a_q, b_q, c_q;
   logic              acc_en_q;
   logic [TileW-1:0]  res_q, res_d;
   logic              ovf_q, ovf_d;
   logic              load;

   logic [RowW-1:0]   a_row;
   logic [RowW-1:0]   c_sel;
   logic [RowW-1:0]   lane_res;
   logic [N-1:0]      lane_ovf;

   // Select row row_q of A and C; C is forced to zero when not accumulating.
   always_comb begin
      a_row = '0;
      c_sel = '0;
      for (int r = 0; r < N; r++) begin
         if (row_q == CntW'(r)) begin
            a_row = a_q[r*RowW +: RowW];
            c_sel = acc_en_q ? c_q[r*RowW +: RowW] : '0;
         end
      end
   end

   // Lane j owns output column j; B is column-major so its column is a contiguous slice.
   for (genvar j = 0; j < N; j++) begin : g_lane
      tensor_dot #(
         .N   (N),
         .DW  (DW),
         .SAT (SAT)
      ) u_dot (
         .row    (a_row),
         .col    (b_q[j*RowW +: RowW]),
         .addend (c_sel[j*DW +: DW]),
         .res    (lane_res[j*DW +: DW]),
         .ovf    (lane_ovf[j])
      );
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               load    = 1'b1;
               ovf_d   = 1'b0;
               row_d   = '0;
               state_d = StCompute;
            end
         end
         StCompute: begin
            for (int r = 0; r < N; r++) begin
               if (row_q == CntW'(r)) begin
                  res_d[r*RowW +: RowW] = lane_res;
               end
            end
            ovf_d = ovf_q | (|lane_ovf);
            if (row_q == LastRow) begin
               row_d   = '0;
               state_d = StDone;
            end else begin
               row_d = row_q + CntW'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         row_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         acc_en_q <= 1'b0;
      end else if (load) begin
         a_q      <= rs;
         b_q      <= rt;
         c_q      <= rc;
         acc_en_q <= acc_en;
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign out_valid  = (state_q == StDone);
   assign tensor_out = res_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_tensor_mma.sv
// tb_tensor_mma: drives a saturating and a wrapping tensor_mma (N=4, DW=8) with the same
// operands; checks table vectors, randomized operations against a behavioural model,
// backpressure and mid-operation reset.
module tb_tensor_mma;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned TW = DW * N * N;

   typedef struct {
      string          name;
      logic [TW-1:0]  a;
      logic [TW-1:0]  b;
      logic [TW-1:0]  c;
      bit             acc;
      logic [TW-1:0]  exp_sat;
      logic [TW-1:0]  exp_wrap;
      bit             exp_ovf;
   } vec_t;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          acc_en;
   logic [TW-1:0] rs, rt, rc;
   logic          out_ready;

   logic          in_ready_s, out_valid_s, ovf_s;
   logic          in_ready_w, out_valid_w, ovf_w;
   logic [TW-1:0] d_s, d_w;

   int applied;
   int miscompares;

   tensor_mma #(.N(N), .DW(DW), .SAT(1)) u_sat (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready_s),
      .acc_en     (acc_en),
      .rs         (rs),
      .rt         (rt),
      .rc         (rc),
      .out_valid  (out_valid_s),
      .out_ready  (out_ready),
      .tensor_out (d_s),
      .ovf        (ovf_s)
   );

   tensor_mma #(.N(N), .DW(DW), .SAT(0)) u_wrap (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready_w),
      .acc_en     (acc_en),
      .rs         (rs),
      .rt         (rt),
      .rc         (rc),
      .out_valid  (out_valid_w),
      .out_ready  (out_ready),
      .tensor_out (d_w),
      .ovf        (ovf_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1);
   end

   function automatic logic [TW-1:0] fill(input int v);
      logic [TW-1:0] r;
      for (int e = 0; e < N * N; e++) r[e*DW +: DW] = DW'(v);
      return r;
   endfunction

   function automatic logic [TW-1:0] ident();
      logic [TW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[(i*N+i)*DW +: DW] = DW'(1);
      return r;
   endfunction

   // Column-major B laid out row-major: what A=I must produce.
   function automatic logic [TW-1:0] col_to_row(input logic [TW-1:0] b);
      logic [TW-1:0] r;
      for (int k = 0; k < N; k++)
         for (int j = 0; j < N; j++)
            r[(k*N+j)*DW +: DW] = b[(j*N+k)*DW +: DW];
      return r;
   endfunction

   function automatic logic [TW-1:0] rand_tile();
      logic [TW-1:0] r;
      int            pick;
      for (int e = 0; e < N * N; e++) begin
         pick = int'($urandom_range(0, 7));
         if (pick == 0)      r[e*DW +: DW] = DW'(127);
         else if (pick == 1) r[e*DW +: DW] = DW'(-128);
         else                r[e*DW +: DW] = DW'($urandom_range(0, 255));
      end
      return r;
   endfunction

   // Reference: plain integer matrix arithmetic on the decoded elements.
   function automatic void model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                 input logic [TW-1:0] c, input bit acc,
                                 output logic [TW-1:0] ds, output logic [TW-1:0] dw,
                                 output bit ov);
      longint               s, hi, lo, cl;
      logic signed [DW-1:0] ea, eb, ec;
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -hi - 1;
      ov = 1'b0;
      ds = '0;
      dw = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            ec = c[DW*(i*N+j) +: DW];
            s  = acc ? longint'(ec) : 0;
            for (int k = 0; k < N; k++) begin
               ea = a[DW*(i*N+k) +: DW];
               eb = b[DW*(j*N+k) +: DW];
               s  = s + longint'(ea) * longint'(eb);
            end
            if (s > hi || s < lo) ov = 1'b1;
            cl = (s > hi) ? hi : ((s < lo) ? lo : s);
            ds[DW*(i*N+j) +: DW] = DW'(cl);
            dw[DW*(i*N+j) +: DW] = DW'(s);
         end
      end
   endfunction

   task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Starts and ends at a falling edge. Issues one operation, checks latency and results
   // of both instances, then takes the result.
   task automatic run_op(input string name, input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic [TW-1:0] c, input bit acc, input logic [TW-1:0] es,
                         input logic [TW-1:0] ew, input bit eo);
      int budget;
      int lat;
      budget = 0;
      while (!in_ready_s && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check({name, " in_ready before issue"}, TW'(in_ready_s), TW'(1));
      rs       = a;
      rt       = b;
      rc       = c;
      acc_en   = acc;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      // Operands must have been captured; scramble the live inputs.
      rs       = ~a;
      rt       = ~b;
      rc       = ~c;
      acc_en   = ~acc;
      lat      = 0;
      while (!out_valid_s && lat < 4 * N) begin
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, TW'(lat), TW'(N));
      check({name, " wrap out_valid"}, TW'(out_valid_w), TW'(1));
      check({name, " sat D"}, d_s, es);
      check({name, " sat ovf"}, TW'(ovf_s), TW'(eo));
      check({name, " wrap D"}, d_w, ew);
      check({name, " wrap ovf"}, TW'(ovf_w), TW'(eo));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, " out_valid after take"}, TW'(out_valid_s), TW'(0));
      check({name, " in_ready after take"}, TW'(in_ready_s), TW'(1));
   endtask

   vec_t          tbl [5];
   logic [TW-1:0] arb, ra, rb, rcv, es, ew, hold;
   bit            eo, racc;

   initial begin
      applied     = 0;
      miscompares = 0;
      reset       = 1'b0;
      in_valid    = 1'b0;
      acc_en      = 1'b0;
      rs          = '0;
      rt          = '0;
      rc          = '0;
      out_ready   = 1'b0;

      arb = '0;
      for (int e = 0; e < N * N; e++) arb[e*DW +: DW] = DW'(e * 11 - 70);

      tbl[0] = '{"identity", ident(), arb, fill(9), 1'b0,
                 col_to_row(arb), col_to_row(arb), 1'b0};
      tbl[1] = '{"all127", fill(127), fill(127), fill(0), 1'b0,
                 fill(127), fill(8'h04), 1'b1};
      tbl[2] = '{"neg_acc", fill(-128), fill(127), fill(5), 1'b1,
                 fill(-128), fill(8'h05), 1'b1};
      tbl[3] = '{"ident_acc", ident(), fill(3), fill(-2), 1'b1,
                 fill(1), fill(1), 1'b0};
      tbl[4] = '{"ident_noacc", ident(), fill(3), fill(-2), 1'b0,
                 fill(3), fill(3), 1'b0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset out_valid", TW'(out_valid_s), TW'(0));
      check("reset tensor_out", d_s, '0);
      check("reset ovf", TW'(ovf_s), TW'(0));
      reset = 1'b1;
      @(negedge clk);
      check("in_ready after release", TW'(in_ready_s), TW'(1));

      for (int t = 0; t < 5; t++) begin
         run_op(tbl[t].name, tbl[t].a, tbl[t].b, tbl[t].c, tbl[t].acc,
                tbl[t].exp_sat, tbl[t].exp_wrap, tbl[t].exp_ovf);
      end

      for (int t = 0; t < 16; t++) begin
         ra   = rand_tile();
         rb   = rand_tile();
         rcv  = rand_tile();
         racc = 1'($urandom_range(0, 1));
         model(ra, rb, rcv, racc, es, ew, eo);
         run_op($sformatf("rand%0d", t), ra, rb, rcv, racc, es, ew, eo);
      end

      // Backpressure: hold result for 10 cycles while offering new operands.
      ra  = rand_tile();
      rb  = rand_tile();
      rcv = rand_tile();
      model(ra, rb, rcv, 1'b1, es, ew, eo);
      rs       = ra;
      rt       = rb;
      rc       = rcv;
      acc_en   = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int w = 0; w < 4 * N && !out_valid_s; w++) @(negedge clk);
      check("bp out_valid", TW'(out_valid_s), TW'(1));
      check("bp D", d_s, es);
      hold     = d_s;
      rs       = fill(1);
      rt       = fill(1);
      rc       = fill(1);
      in_valid = 1'b1;
      for (int w = 0; w < 10; w++) begin
         @(negedge clk);
         check("bp stable D", d_s, es);
         check("bp in_ready low", TW'(in_ready_s), TW'(0));
      end
      check("bp ovf held", TW'(ovf_s), TW'(eo));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp in_ready after release", TW'(in_ready_s), TW'(1));
      check("bp out_valid after release", TW'(out_valid_s), TW'(0));
      @(negedge clk);
      check("bp no stray accept", TW'(in_ready_s), TW'(1));
      check("bp result untouched", d_s, hold);

      // Reset while computing row 2.
      rs       = fill(127);
      rt       = fill(127);
      rc       = fill(0);
      acc_en   = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre-reset ovf set", TW'(ovf_s), TW'(1));
      reset = 1'b0;
      #1;
      check("rst out_valid", TW'(out_valid_s), TW'(0));
      check("rst tensor_out", d_s, '0);
      check("rst ovf", TW'(ovf_s), TW'(0));
      check("rst wrap tensor_out", d_w, '0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst in_ready after release", TW'(in_ready_s), TW'(1));
      check("rst out_valid after release", TW'(out_valid_s), TW'(0));
      ra  = rand_tile();
      rb  = rand_tile();
      rcv = rand_tile();
      model(ra, rb, rcv, 1'b1, es, ew, eo);
      run_op("post_reset", ra, rb, rcv, 1'b1, es, ew, eo);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
